// File: rtl/prog_sequencer_if.sv
// Handshake and report bundle between the program sequencer and its
// surroundings. The sequencer uses the master view; the testbench/top and
// core side use the slave view.
`timescale 1ns/1ps
interface prog_sequencer_if #(
  parameter int PW = 2,
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic          core_done;
  logic          core_rst;
  logic [PW-1:0] prog_sel;
  logic          busy;
  logic          all_done;
  logic          rpt_valid;
  logic [PW-1:0] rpt_prog;
  logic [CW-1:0] rpt_cycles;
  logic          rpt_timeout;
  logic [PW:0]   fail_cnt;

  modport master (
    input  start, abort, core_done,
    output core_rst, prog_sel, busy, all_done,
           rpt_valid, rpt_prog, rpt_cycles, rpt_timeout, fail_cnt
  );

  modport slave (
    output start, abort, core_done,
    input  core_rst, prog_sel, busy, all_done,
           rpt_valid, rpt_prog, rpt_cycles, rpt_timeout, fail_cnt
  );
endinterface

// File: rtl/prog_sequencer.sv
// Multi-program run controller: runs NPROG programs back-to-back on one
// core. Each program is selected, the core is held in reset for RST_CYC
// cycles, released, and timed until core_done or TIMEOUT; a one-cycle
// report is posted before moving to the next program.
`timescale 1ns/1ps
module prog_sequencer #(
  parameter int NPROG   = 3,
  parameter int PW      = 2,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096,
  parameter int RST_CYC = 2
) (
  input logic               clk,
  input logic               reset,
  prog_sequencer_if.master  bus
);

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, RUN, REPORT} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_next;
  logic          last_prog;
  logic          fail_sat;

  // Cycle count including the current RUN cycle, and end-of-sequence detect.
  always_comb begin
    run_next  = run_cnt + 1'b1;
    last_prog = (bus.prog_sel == PW'(NPROG - 1));
    fail_sat  = (bus.fail_cnt == {(PW+1){1'b1}});
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      run_cnt         <= '0;
      bus.core_rst    <= 1'b1;
      bus.prog_sel    <= '0;
      bus.busy        <= 1'b0;
      bus.all_done    <= 1'b0;
      bus.rpt_valid   <= 1'b0;
      bus.rpt_prog    <= '0;
      bus.rpt_cycles  <= '0;
      bus.rpt_timeout <= 1'b0;
      bus.fail_cnt    <= '0;
    end else begin
      bus.rpt_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.core_rst <= 1'b1;
          bus.busy     <= 1'b0;
          if (bus.start) begin
            state        <= HOLD;
            bus.busy     <= 1'b1;
            bus.prog_sel <= '0;
            bus.all_done <= 1'b0;
            bus.fail_cnt <= '0;
            hold_cnt     <= '0;
          end
        end
        HOLD: begin
          if (bus.abort) begin
            state        <= IDLE;
            bus.core_rst <= 1'b1;
            bus.busy     <= 1'b0;
          end else if (hold_cnt == HW'(RST_CYC - 1)) begin
            state        <= RUN;
            bus.core_rst <= 1'b0;
            run_cnt      <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state        <= IDLE;
            bus.core_rst <= 1'b1;
            bus.busy     <= 1'b0;
          end else if (bus.core_done) begin
            state           <= REPORT;
            bus.core_rst    <= 1'b1;
            bus.rpt_valid   <= 1'b1;
            bus.rpt_prog    <= bus.prog_sel;
            bus.rpt_cycles  <= run_next;
            bus.rpt_timeout <= 1'b0;
          end else if (run_next == CW'(TIMEOUT)) begin
            state           <= REPORT;
            bus.core_rst    <= 1'b1;
            bus.rpt_valid   <= 1'b1;
            bus.rpt_prog    <= bus.prog_sel;
            bus.rpt_cycles  <= CW'(TIMEOUT);
            bus.rpt_timeout <= 1'b1;
            if (!fail_sat) begin
              bus.fail_cnt <= bus.fail_cnt + 1'b1;
            end
          end else begin
            run_cnt <= run_next;
          end
        end
        REPORT: begin
          bus.core_rst <= 1'b1;
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (last_prog) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.all_done <= 1'b1;
          end else begin
            state        <= HOLD;
            bus.prog_sel <= bus.prog_sel + 1'b1;
            hold_cnt     <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.core_rst <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer. Two instances share clock and
// reset: dut_a with the default TIMEOUT and dut_b with TIMEOUT=8. A small
// core model per instance raises core_done in a chosen RUN cycle per program.
`timescale 1ns/1ps
module tb_prog_sequencer;

  localparam int PW = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  prog_sequencer_if #(.PW(PW), .CW(CW)) bus_a ();
  prog_sequencer_if #(.PW(PW), .CW(CW)) bus_b ();

  prog_sequencer #(.NPROG(3), .PW(PW), .CW(CW), .TIMEOUT(4096), .RST_CYC(2))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  prog_sequencer #(.NPROG(3), .PW(PW), .CW(CW), .TIMEOUT(8), .RST_CYC(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Core models: done in RUN cycle done_at[prog] (0 = never), plus a force.
  int   done_at_a [4];
  int   done_at_b [4];
  logic force_a = 1'b0;
  int   run_a;
  int   run_b;

  // Count RUN cycles seen by each core model while its reset is released.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_a <= 0;
      run_b <= 0;
    end else begin
      run_a <= bus_a.core_rst ? 0 : run_a + 1;
      run_b <= bus_b.core_rst ? 0 : run_b + 1;
    end
  end

  assign bus_a.core_done = force_a |
    (!bus_a.core_rst && (done_at_a[bus_a.prog_sel] != 0) &&
     (run_a == done_at_a[bus_a.prog_sel] - 1));
  assign bus_b.core_done =
    (!bus_b.core_rst && (done_at_b[bus_b.prog_sel] != 0) &&
     (run_b == done_at_b[bus_b.prog_sel] - 1));

  int compared = 0;
  int mismatched = 0;

  int n;
  int rep_n;
  int rp   [8];
  int rc   [8];
  int rt   [8];
  int rpos [8];

  logic          s_core_rst;
  logic [PW-1:0] s_prog_sel;
  logic          s_busy;
  logic          s_all_done;
  logic          s_rpt_valid;
  logic [PW-1:0] s_rpt_prog;
  logic [CW-1:0] s_rpt_cycles;
  logic          s_rpt_timeout;
  logic [PW:0]   s_fail_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) bus_a.start = v;
    else            bus_b.start = v;
  endtask

  task automatic set_abort(input int which, input logic v);
    if (which == 0) bus_a.abort = v;
    else            bus_b.abort = v;
  endtask

  // Advance to the next falling edge, snapshot one instance, log reports.
  task automatic step(input int which);
    @(negedge clk);
    n++;
    if (which == 0) begin
      s_core_rst = bus_a.core_rst;  s_prog_sel = bus_a.prog_sel;
      s_busy = bus_a.busy;          s_all_done = bus_a.all_done;
      s_rpt_valid = bus_a.rpt_valid; s_rpt_prog = bus_a.rpt_prog;
      s_rpt_cycles = bus_a.rpt_cycles; s_rpt_timeout = bus_a.rpt_timeout;
      s_fail_cnt = bus_a.fail_cnt;
    end else begin
      s_core_rst = bus_b.core_rst;  s_prog_sel = bus_b.prog_sel;
      s_busy = bus_b.busy;          s_all_done = bus_b.all_done;
      s_rpt_valid = bus_b.rpt_valid; s_rpt_prog = bus_b.rpt_prog;
      s_rpt_cycles = bus_b.rpt_cycles; s_rpt_timeout = bus_b.rpt_timeout;
      s_fail_cnt = bus_b.fail_cnt;
    end
    if (s_rpt_valid && rep_n < 8) begin
      rp[rep_n]   = int'(s_rpt_prog);
      rc[rep_n]   = int'(s_rpt_cycles);
      rt[rep_n]   = int'(s_rpt_timeout);
      rpos[rep_n] = n;
      rep_n++;
    end
  endtask

  // One-cycle start pulse; n counts falling edges after the start edge.
  task automatic applyStimulus(input int which);
    n = 0;
    rep_n = 0;
    for (int i = 0; i < 8; i++) begin
      rp[i] = 99; rc[i] = -1; rt[i] = 9; rpos[i] = -1;
    end
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
  endtask

  // Step until all_done; optionally poke start while the sequence is busy.
  task automatic run_to_done(input int which, input bit poke, input int max);
    for (int i = 0; i < max; i++) begin
      if (poke) set_start(which, (n == 3 || n == 10 || n == 21));
      step(which);
      if (s_all_done) break;
    end
    set_start(which, 1'b0);
    checkOutput("all_done_wait", s_all_done, 1);
  endtask

  task automatic expect_rep(input string t, input int idx, input int prog,
                            input int cyc, input int to, input int at);
    checkOutput($sformatf("%s_rep%0d_prog", t, idx), rp[idx], prog);
    checkOutput($sformatf("%s_rep%0d_cycles", t, idx), rc[idx], cyc);
    checkOutput($sformatf("%s_rep%0d_timeout", t, idx), rt[idx], to);
    checkOutput($sformatf("%s_rep%0d_at", t, idx), rpos[idx], at);
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done_at_a[i] = 0;
      done_at_b[i] = 0;
    end
    n = 0;
    rep_n = 0;

    // Reset state
    step(0);
    step(0);
    checkOutput("rst_core_rst", s_core_rst, 1);
    checkOutput("rst_busy", s_busy, 0);
    checkOutput("rst_prog_sel", s_prog_sel, 0);
    checkOutput("rst_all_done", s_all_done, 0);
    checkOutput("rst_rpt_valid", s_rpt_valid, 0);
    checkOutput("rst_fail_cnt", s_fail_cnt, 0);
    reset = 1'b1;
    step(0);
    checkOutput("idle_core_rst", s_core_rst, 1);

    // Three programs done after 5, 9, 3 RUN cycles
    done_at_a[0] = 5; done_at_a[1] = 9; done_at_a[2] = 3;
    applyStimulus(0);
    run_to_done(0, 1'b0, 100);
    checkOutput("t1_rep_count", rep_n, 3);
    expect_rep("t1", 0, 0, 5, 0, 8);
    expect_rep("t1", 1, 1, 9, 0, 20);
    expect_rep("t1", 2, 2, 3, 0, 26);
    checkOutput("t1_done_at", n, 27);
    checkOutput("t1_busy", s_busy, 0);
    checkOutput("t1_core_rst", s_core_rst, 1);
    checkOutput("t1_rpt_valid_low", s_rpt_valid, 0);
    checkOutput("t1_rpt_prog_held", s_rpt_prog, 2);
    checkOutput("t1_rpt_cycles_held", s_rpt_cycles, 3);
    step(0);
    checkOutput("t1_all_done_sticky", s_all_done, 1);

    // Same sequence with start pulses while busy: nothing may change
    applyStimulus(0);
    run_to_done(0, 1'b1, 100);
    checkOutput("t5s_rep_count", rep_n, 3);
    expect_rep("t5s", 0, 0, 5, 0, 8);
    expect_rep("t5s", 1, 1, 9, 0, 20);
    expect_rep("t5s", 2, 2, 3, 0, 26);

    // TIMEOUT=8, program 1 never finishes
    done_at_b[0] = 4; done_at_b[1] = 0; done_at_b[2] = 6;
    step(1);
    applyStimulus(1);
    run_to_done(1, 1'b0, 100);
    checkOutput("t2_rep_count", rep_n, 3);
    expect_rep("t2", 0, 0, 4, 0, 7);
    expect_rep("t2", 1, 1, 8, 1, 18);
    expect_rep("t2", 2, 2, 6, 0, 27);
    checkOutput("t2_fail_cnt", s_fail_cnt, 1);
    checkOutput("t2_done_at", n, 28);

    // Done on exactly the TIMEOUT-th cycle is a completion
    done_at_b[0] = 8; done_at_b[1] = 2; done_at_b[2] = 8;
    applyStimulus(1);
    step(1);
    checkOutput("t3_fail_cleared", s_fail_cnt, 0);
    checkOutput("t3_all_done_cleared", s_all_done, 0);
    run_to_done(1, 1'b0, 100);
    expect_rep("t3", 0, 0, 8, 0, 11);
    expect_rep("t3", 1, 1, 2, 0, 16);
    expect_rep("t3", 2, 2, 8, 0, 27);
    checkOutput("t3_fail_cnt", s_fail_cnt, 0);

    // Abort during program 1 RUN (program 0 times out first)
    done_at_b[0] = 0; done_at_b[1] = 0; done_at_b[2] = 0;
    applyStimulus(1);
    while (n < 16) step(1);
    checkOutput("t4_busy_before", s_busy, 1);
    checkOutput("t4_prog_before", s_prog_sel, 1);
    checkOutput("t4_in_run", s_core_rst, 0);
    set_abort(1, 1'b1);
    step(1);
    set_abort(1, 1'b0);
    checkOutput("t4_busy", s_busy, 0);
    checkOutput("t4_core_rst", s_core_rst, 1);
    checkOutput("t4_all_done", s_all_done, 0);
    checkOutput("t4_fail_cnt_kept", s_fail_cnt, 1);
    for (int i = 0; i < 12; i++) step(1);
    checkOutput("t4_rep_count", rep_n, 1);
    checkOutput("t4_still_idle", s_busy, 0);
    done_at_b[0] = 2; done_at_b[1] = 2; done_at_b[2] = 2;
    applyStimulus(1);
    step(1);
    checkOutput("t4_restart_prog", s_prog_sel, 0);
    checkOutput("t4_restart_fail", s_fail_cnt, 0);
    checkOutput("t4_restart_busy", s_busy, 1);
    run_to_done(1, 1'b0, 100);
    expect_rep("t4r", 2, 2, 2, 0, 15);

    // core_done held high through IDLE and HOLD
    done_at_a[0] = 5; done_at_a[1] = 2; done_at_a[2] = 2;
    force_a = 1'b1;
    step(0);
    applyStimulus(0);
    for (int i = 0; i < 3; i++) step(0);
    checkOutput("t6_no_early_rep", rep_n, 0);
    step(0);
    force_a = 1'b0;
    run_to_done(0, 1'b0, 100);
    expect_rep("t6", 0, 0, 1, 0, 4);
    expect_rep("t6", 1, 1, 2, 0, 9);
    expect_rep("t6", 2, 2, 2, 0, 14);

    // Asynchronous reset between clock edges in program 1 RUN
    done_at_a[0] = 5; done_at_a[1] = 9; done_at_a[2] = 3;
    applyStimulus(0);
    while (n < 13) step(0);
    checkOutput("t5_busy_before", s_busy, 1);
    checkOutput("t5_prog_before", s_prog_sel, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_core_rst", bus_a.core_rst, 1);
    checkOutput("t5_busy", bus_a.busy, 0);
    checkOutput("t5_prog_sel", bus_a.prog_sel, 0);
    checkOutput("t5_all_done", bus_a.all_done, 0);
    checkOutput("t5_rpt_valid", bus_a.rpt_valid, 0);
    checkOutput("t5_rpt_cycles", bus_a.rpt_cycles, 0);
    checkOutput("t5_rpt_timeout", bus_a.rpt_timeout, 0);
    checkOutput("t5_b_rpt_cycles", bus_b.rpt_cycles, 0);
    checkOutput("t5_b_all_done", bus_b.all_done, 0);
    step(0);
    reset = 1'b1;
    step(0);
    step(0);
    checkOutput("t5_idle_after", s_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Multi-program run controller that sits between the testbench/top and a processor core instance. It runs NPROG programs back-to-back on one core. For each program it:
- selects the program,
- holds the core in reset for a fixed number of cycles,
- releases the core and counts cycles until the core raises its done flag or a timeout expires,
- posts a one-cycle result report, then moves to the next program.

It generalises the single-program start/done flow to N programs, with cycle measurement, timeout and abort.

Parameters:
NPROG, 3, number of programs run per start (>=1)
PW, 2, width of prog_sel/rpt_prog; must satisfy 2^PW >= NPROG
CW, 16, width of cycle counter and rpt_cycles
TIMEOUT, 4096, RUN cycles without core_done before the program is declared timed out (1 <= TIMEOUT <= 2^CW-1)
RST_CYC, 2, cycles core_rst is held high before each program (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a sequence; sampled only in IDLE
abort  input  1  terminate current sequence; sampled in any non-IDLE state
core_done  input  1  done flag from the core; sampled only in RUN
core_rst  output  1  active-high reset to the core
prog_sel  output  PW  program index driven to the core's instruction ROM select
busy  output  1  high in every state except IDLE
all_done  output  1  sticky: high after the last program reports; cleared by next accepted start or by reset
rpt_valid  output  1  one-cycle pulse; report fields are valid
rpt_prog  output  PW  program index being reported
rpt_cycles  output  CW  RUN cycle count for the reported program
rpt_timeout  output  1  reported program hit TIMEOUT
fail_cnt  output  PW+1  timed-out programs in the current sequence, saturating

Behaviour:
- reset low (async): state=IDLE, core_rst=1, prog_sel=0, busy=0, all_done=0, rpt_valid=0, rpt_prog=0, rpt_cycles=0, rpt_timeout=0, fail_cnt=0, internal counters=0. Reset overrides every other input.
- States: IDLE, HOLD, RUN, REPORT. All outputs are registered.
- IDLE: core_rst=1, busy=0.
  - start=1 -> HOLD next cycle.
  - On that transition: prog_sel=0, all_done=0, fail_cnt=0.
- HOLD: core_rst=1.
  - Hold counter counts RST_CYC cycles, then -> RUN.
  - core_done is ignored.
- RUN: core_rst=0, run counter starts at 0 and increments each RUN cycle.
  - core_done=1 in the k-th RUN cycle (k=1 for the first) -> REPORT with rpt_cycles=k, rpt_timeout=0.
  - If the counter reaches TIMEOUT with core_done=0 -> REPORT with rpt_cycles=TIMEOUT, rpt_timeout=1, fail_cnt+1 (saturates at 2^(PW+1)-1).
  - core_done=1 on the TIMEOUT-th cycle counts as done, not timeout.
- REPORT (exactly 1 cycle): rpt_valid=1, rpt_prog=prog_sel, core_rst=1.
  - If prog_sel==NPROG-1: -> IDLE, all_done=1, prog_sel held.
  - Otherwise: prog_sel+1, -> HOLD.
  - rpt_* fields hold their last value after the pulse.
- abort=1 in HOLD/RUN/REPORT: next cycle IDLE, core_rst=1, all_done stays 0, no rpt_valid pulse.
  - abort in the REPORT cycle: the already-scheduled pulse in that cycle stands.
  - abort has priority over core_done and timeout in the same cycle.
- start while busy is ignored. start and abort together in IDLE: start wins (abort has no meaning in IDLE).
- core_done held high across program boundaries is harmless: it is only sampled in RUN, and the core is in reset in HOLD.
- Per program latency from REPORT to the next RUN: 1 + RST_CYC cycles.

Test Plan:
1. NPROG=3, RST_CYC=2; core_done asserted after 5, 9, 3 RUN cycles -> three rpt_valid pulses with (prog, cycles) = (0,5), (1,9), (2,3); rpt_timeout=0; all_done=1 the cycle after the third report; busy=0; core_rst=1.
2. TIMEOUT=8, program 1 never asserts done -> report (1,8,timeout=1), fail_cnt=1, sequence continues to program 2, all_done=1 at end.
3. core_done on exactly the 8th RUN cycle with TIMEOUT=8 -> rpt_cycles=8, rpt_timeout=0, fail_cnt=0.
4. abort during program 1 RUN -> next cycle IDLE, core_rst=1, no report for program 1, all_done=0. A subsequent start restarts at prog_sel=0 with fail_cnt=0.
5. Async reset pulsed low mid-RUN (between clock edges) -> all outputs at reset values immediately. start pulses while busy -> no effect on prog_sel or the report sequence.
6. core_done held high during HOLD -> no report until the first RUN cycle; the report then shows rpt_cycles=1.
